// File: rtl/wb_regfile.sv
// wb_regfile
//    Write-back stage and register file at the consumer end of the MEM/WB register.
//    Selects the write-back value, commits it to a GPR array (entry 0 is hard zero),
//    and updates the HI/LO pair for move/multiply results. Two combinational
//    read ports serve ID. HI/LO outputs serve EX. When BYPASS=1, a write in the
//    current cycle is forwarded to the read ports and to HIo/LOo.
//
// Parameters
//    DATA_W  datapath width
//    ADDR_W  GPR address width (2**ADDR_W entries)
//    BYPASS  1 = forward same-cycle writes to the read ports, 0 = show stored values
//
// Ports
//    CLK, RST            rising-edge clock, synchronous active-high reset
//    PCPlus4i, datai     link value and load data from MEM/WB
//    ALUResi, Wloi       ALU result (or HI of product) and LO of product
//    WAddri, whatToRegi  destination GPR and write-back source select
//    regWritei, movei    GPR write enable and HI/LO update code
//    RAddr1/2, RData1/2  ID read ports
//    HIo, LOo            current HI/LO values
//    WDatao              selected write-back value, used for EX/MEM forwarding
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] PCPlus4i,
   input  logic [DATA_W-1:0] datai,
   input  logic [DATA_W-1:0] ALUResi,
   input  logic [DATA_W-1:0] Wloi,
   input  logic [ADDR_W-1:0] WAddri,
   input  logic [1:0]        whatToRegi,
   input  logic              regWritei,
   input  logic [1:0]        movei,
   input  logic [ADDR_W-1:0] RAddr1,
   input  logic [ADDR_W-1:0] RAddr2,
   output logic [DATA_W-1:0] RData1,
   output logic [DATA_W-1:0] RData2,
   output logic [DATA_W-1:0] HIo,
   output logic [DATA_W-1:0] LOo,
   output logic [DATA_W-1:0] WDatao
);

   localparam int N_REG = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_gpr [N_REG];
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;

   logic [DATA_W-1:0] w_wdata;
   logic              w_gpr_we;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic [DATA_W-1:0] w_hi;
   logic [DATA_W-1:0] w_lo;

   // 2'b11 is reserved and falls back to the ALU result.
   always_comb begin
      w_wdata = ALUResi;
      case (whatToRegi)
         2'b01:   w_wdata = datai;
         2'b10:   w_wdata = PCPlus4i;
         default: w_wdata = ALUResi;
      endcase
   end

   assign w_gpr_we = regWritei && (WAddri != '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < N_REG; i++) begin
            r_gpr[i] <= '0;
         end
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (w_gpr_we) begin
            r_gpr[WAddri] <= w_wdata;
         end
         case (movei)
            2'b01: begin
               r_hi <= ALUResi;
               r_lo <= Wloi;
            end
            2'b10:   r_hi <= ALUResi;
            2'b11:   r_lo <= ALUResi;
            default: ;
         endcase
      end
   end

   // Address 0 reads zero even if a bypass would match. Entry 0 itself stays 0
   // because w_gpr_we excludes it, but the explicit check keeps reads
   // independent of the array contents.
   always_comb begin
      w_rd1 = r_gpr[RAddr1];
      if (BYPASS != 0 && w_gpr_we && (RAddr1 == WAddri)) begin
         w_rd1 = w_wdata;
      end
      if (RAddr1 == '0) begin
         w_rd1 = '0;
      end
   end

   always_comb begin
      w_rd2 = r_gpr[RAddr2];
      if (BYPASS != 0 && w_gpr_we && (RAddr2 == WAddri)) begin
         w_rd2 = w_wdata;
      end
      if (RAddr2 == '0) begin
         w_rd2 = '0;
      end
   end

   always_comb begin
      w_hi = r_hi;
      w_lo = r_lo;
      if (BYPASS != 0) begin
         if (movei == 2'b01 || movei == 2'b10) begin
            w_hi = ALUResi;
         end
         if (movei == 2'b01) begin
            w_lo = Wloi;
         end else if (movei == 2'b11) begin
            w_lo = ALUResi;
         end
      end
   end

   assign WDatao = w_wdata;
   assign RData1 = w_rd1;
   assign RData2 = w_rd2;
   assign HIo    = w_hi;
   assign LOo    = w_lo;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

   typedef struct {
      logic        rst;
      logic        rw;
      logic [1:0]  wsel;
      logic [4:0]  wa;
      logic [31:0] alu;
      logic [31:0] dat;
      logic [31:0] pc;
      logic [31:0] wlo;
      logic [1:0]  mv;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic        chk;
      logic [31:0] wd;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] n1;
      logic [31:0] n2;
      logic [31:0] nhi;
      logic [31:0] nlo;
   } vec_t;

   localparam int N_VEC = 21;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] PCPlus4i, datai, ALUResi, Wloi;
   logic [4:0]  WAddri, RAddr1, RAddr2;
   logic [1:0]  whatToRegi, movei;
   logic        regWritei;

   logic [31:0] b_rd1, b_rd2, b_hi, b_lo, b_wd;
   logic [31:0] n_rd1, n_rd2, n_hi, n_lo, n_wd;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t tbl [N_VEC];
   vec_t sb [$];

   always #5 CLK = ~CLK;

   wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
      .CLK(CLK), .RST(RST), .PCPlus4i(PCPlus4i), .datai(datai), .ALUResi(ALUResi),
      .Wloi(Wloi), .WAddri(WAddri), .whatToRegi(whatToRegi), .regWritei(regWritei),
      .movei(movei), .RAddr1(RAddr1), .RAddr2(RAddr2), .RData1(b_rd1), .RData2(b_rd2),
      .HIo(b_hi), .LOo(b_lo), .WDatao(b_wd)
   );

   wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (
      .CLK(CLK), .RST(RST), .PCPlus4i(PCPlus4i), .datai(datai), .ALUResi(ALUResi),
      .Wloi(Wloi), .WAddri(WAddri), .whatToRegi(whatToRegi), .regWritei(regWritei),
      .movei(movei), .RAddr1(RAddr1), .RAddr2(RAddr2), .RData1(n_rd1), .RData2(n_rd2),
      .HIo(n_hi), .LOo(n_lo), .WDatao(n_wd)
   );

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step=%0d got=0x%08h expected=0x%08h", name, idx, act, exp);
      end
   endtask

   // Drive a vector after the falling edge, queue its expectation, and compare
   // the combinational outputs 1 ns later, well before the next rising edge.
   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      @(negedge CLK);
      RST        = v.rst;
      regWritei  = v.rw;
      whatToRegi = v.wsel;
      WAddri     = v.wa;
      ALUResi    = v.alu;
      datai      = v.dat;
      PCPlus4i   = v.pc;
      Wloi       = v.wlo;
      movei      = v.mv;
      RAddr1     = v.ra1;
      RAddr2     = v.ra2;
      sb.push_back(v);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty step=%0d got=0x0 expected=0x1", idx);
      end else begin
         e = sb.pop_front();
         check("wdata_byp", idx, b_wd, e.wd);
         check("wdata_nob", idx, n_wd, e.wd);
         if (e.chk) begin
            check("rd1_byp", idx, b_rd1, e.r1);
            check("rd2_byp", idx, b_rd2, e.r2);
            check("hi_byp",  idx, b_hi,  e.hi);
            check("lo_byp",  idx, b_lo,  e.lo);
            check("rd1_nob", idx, n_rd1, e.n1);
            check("rd2_nob", idx, n_rd2, e.n2);
            check("hi_nob",  idx, n_hi,  e.nhi);
            check("lo_nob",  idx, n_lo,  e.nlo);
         end
      end
   endtask

   initial begin
      vec_t v;
      logic [31:0] junk;

      // rst rw wsel wa alu dat pc wlo mv ra1 ra2 chk | wd r1 r2 hi lo | n1 n2 nhi nlo
      tbl[0]  = '{1'b0,1'b0,2'd0,5'd0,32'h0,32'h0,32'h0,32'h0,2'd0,5'd5,5'd0,1'b1,
                  32'h0,32'h0,32'h0,32'h0,32'h0, 32'h0,32'h0,32'h0,32'h0};
      tbl[1]  = '{1'b0,1'b1,2'd0,5'd5,32'h1234,32'h0,32'h0,32'h0,2'd0,5'd5,5'd5,1'b1,
                  32'h1234,32'h1234,32'h1234,32'h0,32'h0, 32'h0,32'h0,32'h0,32'h0};
      tbl[2]  = '{1'b0,1'b0,2'd0,5'd0,32'h0,32'h0,32'h0,32'h0,2'd0,5'd5,5'd5,1'b1,
                  32'h0,32'h1234,32'h1234,32'h0,32'h0, 32'h1234,32'h1234,32'h0,32'h0};
      tbl[3]  = '{1'b1,1'b0,2'd0,5'd0,32'h0,32'h0,32'h0,32'h0,2'd0,5'd5,5'd5,1'b1,
                  32'h0,32'h1234,32'h1234,32'h0,32'h0, 32'h1234,32'h1234,32'h0,32'h0};
      tbl[4]  = '{1'b0,1'b0,2'd0,5'd0,32'h0,32'h0,32'h0,32'h0,2'd0,5'd5,5'd5,1'b1,
                  32'h0,32'h0,32'h0,32'h0,32'h0, 32'h0,32'h0,32'h0,32'h0};
      tbl[5]  = '{1'b0,1'b1,2'd0,5'd3,32'hA,32'hB,32'hC,32'h0,2'd0,5'd3,5'd0,1'b1,
                  32'hA,32'hA,32'h0,32'h0,32'h0, 32'h0,32'h0,32'h0,32'h0};
      tbl[6]  = '{1'b0,1'b1,2'd1,5'd3,32'hA,32'hB,32'hC,32'h0,2'd0,5'd3,5'd0,1'b1,
                  32'hB,32'hB,32'h0,32'h0,32'h0, 32'hA,32'h0,32'h0,32'h0};
      tbl[7]  = '{1'b0,1'b1,2'd2,5'd3,32'hA,32'hB,32'hC,32'h0,2'd0,5'd3,5'd0,1'b1,
                  32'hC,32'hC,32'h0,32'h0,32'h0, 32'hB,32'h0,32'h0,32'h0};
      tbl[8]  = '{1'b0,1'b0,2'd3,5'd3,32'hA,32'hB,32'hC,32'h0,2'd0,5'd3,5'd3,1'b1,
                  32'hA,32'hC,32'hC,32'h0,32'h0, 32'hC,32'hC,32'h0,32'h0};
      tbl[9]  = '{1'b0,1'b1,2'd0,5'd0,32'hFFFF_FFFF,32'h0,32'h0,32'h0,2'd0,5'd0,5'd3,1'b1,
                  32'hFFFF_FFFF,32'h0,32'hC,32'h0,32'h0, 32'h0,32'hC,32'h0,32'h0};
      tbl[10] = '{1'b0,1'b0,2'd0,5'd0,32'h0,32'h0,32'h0,32'h0,2'd0,5'd0,5'd3,1'b1,
                  32'h0,32'h0,32'hC,32'h0,32'h0, 32'h0,32'hC,32'h0,32'h0};
      tbl[11] = '{1'b0,1'b1,2'd0,5'd7,32'h1,32'h0,32'h0,32'h0,2'd0,5'd7,5'd7,1'b1,
                  32'h1,32'h1,32'h1,32'h0,32'h0, 32'h0,32'h0,32'h0,32'h0};
      tbl[12] = '{1'b0,1'b1,2'd0,5'd7,32'h55,32'h0,32'h0,32'h0,2'd0,5'd7,5'd7,1'b1,
                  32'h55,32'h55,32'h55,32'h0,32'h0, 32'h1,32'h1,32'h0,32'h0};
      tbl[13] = '{1'b0,1'b0,2'd0,5'd0,32'h0,32'h0,32'h0,32'h0,2'd0,5'd7,5'd7,1'b1,
                  32'h0,32'h55,32'h55,32'h0,32'h0, 32'h55,32'h55,32'h0,32'h0};
      tbl[14] = '{1'b0,1'b0,2'd0,5'd0,32'h11,32'h0,32'h0,32'h22,2'd1,5'd0,5'd0,1'b1,
                  32'h11,32'h0,32'h0,32'h11,32'h22, 32'h0,32'h0,32'h0,32'h0};
      tbl[15] = '{1'b0,1'b0,2'd0,5'd0,32'h33,32'h0,32'h0,32'h0,2'd3,5'd0,5'd0,1'b1,
                  32'h33,32'h0,32'h0,32'h11,32'h33, 32'h0,32'h0,32'h11,32'h22};
      tbl[16] = '{1'b0,1'b1,2'd0,5'd9,32'h44,32'h0,32'h0,32'h0,2'd2,5'd9,5'd7,1'b1,
                  32'h44,32'h44,32'h55,32'h44,32'h33, 32'h0,32'h55,32'h11,32'h33};
      tbl[17] = '{1'b0,1'b0,2'd0,5'd0,32'h0,32'h0,32'h0,32'h0,2'd0,5'd9,5'd7,1'b1,
                  32'h0,32'h44,32'h55,32'h44,32'h33, 32'h44,32'h55,32'h44,32'h33};
      tbl[18] = '{1'b1,1'b1,2'd0,5'd9,32'h99,32'h0,32'h0,32'h77,2'd1,5'd9,5'd5,1'b0,
                  32'h99,32'h0,32'h0,32'h0,32'h0, 32'h0,32'h0,32'h0,32'h0};
      tbl[19] = '{1'b0,1'b0,2'd0,5'd0,32'h0,32'h0,32'h0,32'h0,2'd0,5'd9,5'd7,1'b1,
                  32'h0,32'h0,32'h0,32'h0,32'h0, 32'h0,32'h0,32'h0,32'h0};
      tbl[20] = '{1'b0,1'b0,2'd0,5'd0,32'h0,32'h0,32'h0,32'h0,2'd0,5'd3,5'd5,1'b1,
                  32'h0,32'h0,32'h0,32'h0,32'h0, 32'h0,32'h0,32'h0,32'h0};

      // Initial reset across the first rising edge.
      RST = 1'b1; regWritei = 1'b0; movei = 2'd0; whatToRegi = 2'd0; WAddri = 5'd0;
      ALUResi = 32'h0; datai = 32'h0; PCPlus4i = 32'h0; Wloi = 32'h0;
      RAddr1 = 5'd0; RAddr2 = 5'd0;

      for (int i = 0; i < N_VEC; i++) begin
         apply(tbl[i], i);
      end

      // Load r12, HI and LO, then hold enables low under garbage on the data,
      // address and select inputs; stored state must survive.
      v = tbl[19];
      v.rw = 1'b1; v.wa = 5'd12; v.alu = 32'hDEAD_BEEF; v.wlo = 32'h0000_0006;
      v.mv = 2'd1; v.chk = 1'b0; v.wd = 32'hDEAD_BEEF;
      apply(v, 100);
      for (int k = 0; k < 4; k++) begin
         v = tbl[19];
         v.chk  = 1'b0;
         v.wsel = 2'($urandom_range(0, 3));
         v.wa   = 5'($urandom_range(0, 31));
         v.alu  = $urandom;
         v.dat  = $urandom;
         v.pc   = $urandom;
         v.wlo  = $urandom;
         case (v.wsel)
            2'd1:    junk = v.dat;
            2'd2:    junk = v.pc;
            default: junk = v.alu;
         endcase
         v.wd = junk;
         apply(v, 101 + k);
      end
      v = tbl[19];
      v.ra1 = 5'd12; v.ra2 = 5'd12;
      v.r1 = 32'hDEAD_BEEF; v.r2 = 32'hDEAD_BEEF; v.hi = 32'hDEAD_BEEF; v.lo = 32'h6;
      v.n1 = 32'hDEAD_BEEF; v.n2 = 32'hDEAD_BEEF; v.nhi = 32'hDEAD_BEEF; v.nlo = 32'h6;
      apply(v, 110);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
